// File: rtl/ifu_fetch_ctrl_pkg.sv
// rtl/ifu_fetch_ctrl_pkg.sv - shared constants and types for the instruction-fetch controller
//
// Purpose: widths, reset PC, credit depth, RISC-V opcodes used by the static
//          predictor, and the fetch FSM state encoding.
// Ports:   none (package).
package ifu_fetch_ctrl_pkg;

  localparam int          IFU_ADDR_W = 32;
  localparam logic [31:0] IFU_RST_PC = 32'h8000_0000;
  localparam int          IFU_DEPTH  = 2;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - fetch-side bundle: memory request/response and decoder channels
//
// Purpose: groups the instruction-memory valid/ready channel and the decoder
//          output channel driven by ifu_fetch_ctrl.
// Signals: ifu_req_vld/rdy/addr   request to instruction memory
//          ifu_rsp_vld/instr/rdy  in-order response from instruction memory
//          ifu_o_vld/rdy/instr/pc/prdt_taken  instruction to decoder
// Modports: master = fetch controller side, slave = memory/decoder side.
interface ifu_fetch_ctrl_if
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W
);
  logic              ifu_req_vld;
  logic              ifu_req_rdy;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_rsp_vld;
  logic [31:0]       ifu_rsp_instr;
  logic              ifu_rsp_rdy;
  logic              ifu_o_vld;
  logic              ifu_o_rdy;
  logic [31:0]       ifu_o_instr;
  logic [ADDR_W-1:0] ifu_o_pc;
  logic              ifu_o_prdt_taken;

  modport master (
    output ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
           ifu_o_vld, ifu_o_instr, ifu_o_pc, ifu_o_prdt_taken,
    input  ifu_req_rdy, ifu_rsp_vld, ifu_rsp_instr, ifu_o_rdy
  );

  modport slave (
    input  ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
           ifu_o_vld, ifu_o_instr, ifu_o_pc, ifu_o_prdt_taken,
    output ifu_req_rdy, ifu_rsp_vld, ifu_rsp_instr, ifu_o_rdy
  );
endinterface

// File: rtl/ifu_fifo2.sv
// rtl/ifu_fifo2.sv - 2-entry first-word-fall-through FIFO with synchronous clear
//
// Purpose: buffers fetched {pc, instr, prdt_taken} entries for the decoder.
// Ports:   clk, rst        clock, asynchronous active-high reset
//          clr_i           synchronous clear, wins over a same-cycle push/pop
//          push_i/push_data_i  write side (ignored when full)
//          pop_i           read side (ignored when empty)
//          data_o          head entry, valid whenever empty_o=0
//          empty_o/full_o/cnt_o  occupancy
module ifu_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem0_q, mem1_q;
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign do_push = push_i & (cnt_q != 2'd2);
  assign do_pop  = pop_i  & (cnt_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_q <= push_data_i;
        else          mem0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch controller: PC, request credits, kill tracking, decode FIFO
//
// Purpose: owns the fetch PC, issues in-order requests to instruction memory,
//          drops responses killed by flush or prediction, and buffers results
//          for the decoder. Optional static BTFN prediction is compiled in
//          with `define MYRISCV_IFU_BPU_EN.
// Ports:   clk, rst                 clock, asynchronous active-high reset
//          flush_req, flush_addr    redirect request and target
//          halt_req, halt_ack       debug halt handshake
//          bus (master)             memory request/response + decoder output
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(IFU_RST_PC),
  parameter int                DEPTH  = IFU_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              halt_req,
  output logic              halt_ack,
  ifu_fetch_ctrl_if.master  bus
);
  localparam int FW = ADDR_W + 33;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        out_cnt_q, out_cnt_d;
  logic [1:0]        kill_cnt_q, kill_cnt_d;
  // PCs of in-flight requests, oldest in pcq0 (includes killed ones).
  logic [ADDR_W-1:0] pcq0_q, pcq0_d, pcq1_q, pcq1_d;

  logic              req_vld, req_fire, rsp_vld, rsp_kill, rsp_keep;
  logic [1:0]        cnt_after_rsp;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_tgt;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [1:0]        fifo_cnt;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;

  assign rsp_vld  = bus.ifu_rsp_vld;
  assign rsp_kill = rsp_vld & (kill_cnt_q != 2'd0);
  assign rsp_keep = rsp_vld & (kill_cnt_q == 2'd0);

  assign req_vld  = (state_q == RUN) & ~halt_req & ~flush_req &
                    (({1'b0, out_cnt_q} + {1'b0, fifo_cnt}) < 3'(DEPTH));
  assign req_fire = req_vld & bus.ifu_req_rdy;

`ifdef MYRISCV_IFU_BPU_EN
  logic              is_jal, is_br;
  logic [20:0]       jal_imm;
  logic [12:0]       br_imm;
  logic [ADDR_W-1:0] jal_off, br_off;

  assign is_jal  = (bus.ifu_rsp_instr[6:0] == OPC_JAL);
  assign is_br   = (bus.ifu_rsp_instr[6:0] == OPC_BRANCH);
  assign jal_imm = {bus.ifu_rsp_instr[31], bus.ifu_rsp_instr[19:12],
                    bus.ifu_rsp_instr[20], bus.ifu_rsp_instr[30:21], 1'b0};
  assign br_imm  = {bus.ifu_rsp_instr[31], bus.ifu_rsp_instr[7],
                    bus.ifu_rsp_instr[30:25], bus.ifu_rsp_instr[11:8], 1'b0};
  assign jal_off = {{(ADDR_W-21){jal_imm[20]}}, jal_imm};
  assign br_off  = {{(ADDR_W-13){br_imm[12]}}, br_imm};

  // Backward-taken: JAL always, branches only with a negative offset.
  assign pred_taken = rsp_keep & ~flush_req & (is_jal | (is_br & bus.ifu_rsp_instr[31]));
  assign pred_tgt   = pcq0_q + (is_jal ? jal_off : br_off);
`else
  assign pred_taken = 1'b0;
  assign pred_tgt   = '0;
`endif

  assign cnt_after_rsp = out_cnt_q - {1'b0, rsp_vld};

  always_comb begin
    pc_d       = pc_q;
    kill_cnt_d = kill_cnt_q;
    out_cnt_d  = out_cnt_q + {1'b0, req_fire} - {1'b0, rsp_vld};
    pcq0_d     = pcq0_q;
    pcq1_d     = pcq1_q;

    if (rsp_vld) pcq0_d = pcq1_q;
    if (req_fire) begin
      if (cnt_after_rsp == 2'd0) pcq0_d = pc_q;
      else                       pcq1_d = pc_q;
    end

    if (flush_req) begin
      // Every request still outstanding after this cycle's response is stale.
      pc_d       = flush_addr;
      kill_cnt_d = cnt_after_rsp;
    end else if (pred_taken) begin
      // Same rule as flush, but a request accepted this cycle is also younger.
      pc_d       = pred_tgt;
      kill_cnt_d = cnt_after_rsp + {1'b0, req_fire};
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(4);
      if (rsp_kill) kill_cnt_d = kill_cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    halt_ack = 1'b0;
    case (state_q)
      BOOT:   state_d = RUN;
      // Uses the post-response count so halt_ack follows the last response by one cycle.
      RUN:    if (halt_req && (out_cnt_d == 2'd0)) state_d = HALTED;
      HALTED: begin
        halt_ack = 1'b1;
        if (!halt_req) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RST_PC;
      out_cnt_q  <= 2'd0;
      kill_cnt_q <= 2'd0;
      pcq0_q     <= '0;
      pcq1_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      pcq0_q     <= pcq0_d;
      pcq1_q     <= pcq1_d;
    end
  end

  assign fifo_push  = rsp_keep & ~flush_req;
  assign fifo_pop   = bus.ifu_o_vld & bus.ifu_o_rdy;
  assign fifo_wdata = {pcq0_q, bus.ifu_rsp_instr, pred_taken};

  ifu_fifo2 #(.W(FW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush_req),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .data_o      (fifo_rdata),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .cnt_o       (fifo_cnt)
  );

  assign bus.ifu_req_vld  = req_vld;
  assign bus.ifu_req_addr = pc_q;
  assign bus.ifu_rsp_rdy  = 1'b1;
  assign bus.ifu_o_vld    = ~fifo_empty & ~halt_req;
  assign bus.ifu_o_pc     = fifo_rdata[FW-1:33];
  assign bus.ifu_o_instr  = fifo_rdata[32:1];

`ifdef MYRISCV_IFU_BPU_EN
  assign bus.ifu_o_prdt_taken = fifo_rdata[0] & ~fifo_empty;
`else
  logic unused_prdt;
  assign unused_prdt          = fifo_rdata[0];
  assign bus.ifu_o_prdt_taken = 1'b0;
`endif

  a_no_rsp_when_full: assert property (@(posedge clk) disable iff (rst)
    !(bus.ifu_rsp_vld && fifo_full));
  a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (rst)
    !(bus.ifu_rsp_vld && (out_cnt_q == 2'd0)));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_req = 1'b0;
  logic [31:0] flush_addr = '0;
  logic        halt_req = 1'b0;
  logic        halt_ack;

  ifu_fetch_ctrl_if #(.ADDR_W(32)) bus ();

  ifu_fetch_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .flush_addr (flush_addr),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  bit rsp_en   = 1'b1;
  bit bpu_prog = 1'b0;

  logic [31:0] pend[$];
  logic [31:0] iss[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  logic        got_pt[$];

  logic        s_req_vld, s_o_vld, s_halt_ack, s_pt;
  logic [31:0] s_req_addr, s_o_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_instr(input logic [31:0] a);
    if (bpu_prog && a == 32'h8000_0008) return 32'h0000_1463;  // bne x0,x0,+8
    if (bpu_prog && a == 32'h8000_0010) return 32'hFE00_08E3;  // beq x0,x0,-16
    return {a[24:0], 7'b0010011};
  endfunction

  // One clock: present a response, settle, sample what the next edge will see.
  task automatic step();
    logic [31:0] a;
    if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      bus.ifu_rsp_vld   = 1'b1;
      bus.ifu_rsp_instr = mem_instr(a);
    end else begin
      bus.ifu_rsp_vld   = 1'b0;
      bus.ifu_rsp_instr = '0;
    end
    #1;
    s_req_vld  = bus.ifu_req_vld;
    s_req_addr = bus.ifu_req_addr;
    s_o_vld    = bus.ifu_o_vld;
    s_o_pc     = bus.ifu_o_pc;
    s_pt       = bus.ifu_o_prdt_taken;
    s_halt_ack = halt_ack;
    if (bus.ifu_req_vld && bus.ifu_req_rdy) begin
      pend.push_back(bus.ifu_req_addr);
      iss.push_back(bus.ifu_req_addr);
    end
    if (bus.ifu_o_vld && bus.ifu_o_rdy) begin
      got_pc.push_back(bus.ifu_o_pc);
      got_in.push_back(bus.ifu_o_instr);
      got_pt.push_back(bus.ifu_o_prdt_taken);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_req = 1'b0;
    halt_req = 1'b0;
    pend.delete(); iss.delete(); got_pc.delete(); got_in.delete(); got_pt.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.ifu_req_rdy   = 1'b1;
    bus.ifu_rsp_vld   = 1'b0;
    bus.ifu_rsp_instr = '0;
    bus.ifu_o_rdy     = 1'b1;

    // Reset release, streaming fetch
    do_reset();
    check("rst_req_vld", s_req_vld, 0);
    check("rst_o_vld", s_o_vld, 0);
    check("rst_halt_ack", s_halt_ack, 0);
    check("rst_prdt", s_pt, 0);
    check("rsp_rdy", bus.ifu_rsp_rdy, 1);
    step();
    check("boot_req_vld", s_req_vld, 0);
    step();
    check("req0_vld", s_req_vld, 1);
    check("req0_addr", s_req_addr, 32'h8000_0000);
    check("req0_o_vld", s_o_vld, 0);
    step();
    check("req1_vld", s_req_vld, 1);
    check("req1_addr", s_req_addr, 32'h8000_0004);
    check("req1_o_vld", s_o_vld, 0);
    step();
    check("first_o_vld", s_o_vld, 1);
    check("first_o_pc", s_o_pc, 32'h8000_0000);
    repeat (14) step();
    check("stream_cnt_ok", got_pc.size() >= 6, 1);
    check("stream_instr0", got_in[0], 32'h0000_0013);
    for (int i = 0; i < got_pc.size(); i++) begin
      check("stream_pc", got_pc[i], 32'h8000_0000 + 32'(4 * i));
      check("stream_prdt", got_pt[i], 0);
    end
    for (int i = 0; i < iss.size(); i++)
      check("stream_iss", iss[i], 32'h8000_0000 + 32'(4 * i));

    // Decoder back-pressure
    bus.ifu_o_rdy = 1'b0;
    do_reset();
    repeat (8) step();
    check("bp_iss_cnt", iss.size(), 2);
    check("bp_req_vld", s_req_vld, 0);
    check("bp_o_vld", s_o_vld, 1);
    check("bp_o_pc", s_o_pc, 32'h8000_0000);
    bus.ifu_o_rdy = 1'b1;
    repeat (12) step();
    check("bp_cnt_ok", got_pc.size() >= 4, 1);
    for (int i = 0; i < got_pc.size(); i++)
      check("bp_pc", got_pc[i], 32'h8000_0000 + 32'(4 * i));

    // Flush with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    repeat (4) step();
    check("fl_iss_cnt", iss.size(), 2);
    check("fl_stall", s_req_vld, 0);
    flush_req = 1'b1;
    flush_addr = 32'h8000_0100;
    rsp_en = 1'b1;
    step();
    check("fl_req_vld_in_flush", s_req_vld, 0);
    flush_req = 1'b0;
    step();
    check("fl_req_vld", s_req_vld, 1);
    check("fl_req_addr", s_req_addr, 32'h8000_0100);
    repeat (6) step();
    check("fl_cnt_ok", got_pc.size() >= 2, 1);
    check("fl_pc0", got_pc[0], 32'h8000_0100);
    check("fl_pc1", got_pc[1], 32'h8000_0104);

    // Halt with two in flight, flush while halted
    do_reset();
    rsp_en = 1'b0;
    repeat (4) step();
    halt_req = 1'b1;
    rsp_en = 1'b1;
    step();
    check("h_ack_rsp1", s_halt_ack, 0);
    check("h_req_vld", s_req_vld, 0);
    step();
    check("h_ack_rsp2", s_halt_ack, 0);
    check("h_o_vld_masked", s_o_vld, 0);
    step();
    check("h_ack_rise", s_halt_ack, 1);
    check("h_o_vld_halted", s_o_vld, 0);
    flush_req = 1'b1;
    flush_addr = 32'h0000_0200;
    step();
    check("h_ack_flush", s_halt_ack, 1);
    flush_req = 1'b0;
    step();
    check("h_req_vld_halted", s_req_vld, 0);
    halt_req = 1'b0;
    step();
    check("h_req_vld_release", s_req_vld, 0);
    step();
    check("h_ack_fall", s_halt_ack, 0);
    check("h_resume_vld", s_req_vld, 1);
    check("h_resume_addr", s_req_addr, 32'h0000_0200);
    repeat (4) step();
    check("h_cnt_ok", got_pc.size() >= 1, 1);
    check("h_first_pc", got_pc[0], 32'h0000_0200);

`ifdef MYRISCV_IFU_BPU_EN
    // Static prediction: bne +8 not taken at 0x08, beq -16 taken at 0x10
    bpu_prog = 1'b1;
    do_reset();
    repeat (30) step();
    begin
      logic [31:0] exp_pc [8];
      logic        exp_pt [8];
      exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                 32'h8000_0010, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
      exp_pt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      check("bpu_cnt_ok", got_pc.size() >= 8, 1);
      for (int i = 0; i < 8; i++) begin
        check("bpu_pc", got_pc[i], exp_pc[i]);
        check("bpu_prdt", got_pt[i], exp_pt[i]);
      end
    end
    bpu_prog = 1'b0;
`endif

    // Reset asserted mid-fetch with two in flight
    do_reset();
    rsp_en = 1'b0;
    repeat (4) step();
    check("mr_iss_cnt", iss.size(), 2);
    rst = 1'b1;
    #1;
    check("mr_req_vld", bus.ifu_req_vld, 0);
    check("mr_req_addr", bus.ifu_req_addr, 32'h8000_0000);
    check("mr_o_vld", bus.ifu_o_vld, 0);
    check("mr_halt_ack", halt_ack, 0);
    check("mr_prdt", bus.ifu_o_prdt_taken, 0);
    pend.delete();
    iss.delete();
    rsp_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("mr_boot_req_vld", s_req_vld, 0);
    step();
    check("mr_req_vld_after", s_req_vld, 1);
    check("mr_req_addr_after", s_req_addr, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
